// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared sizing defaults and state encoding for the RAM fill controller
package ram_ctrl_pkg;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 2 ** AW;
  typedef enum logic [1:0] {FILL, FULL, ZERO} state_e;
endpackage

// File: rtl/ram_fill_ctrl_if.sv
// ram_fill_ctrl_if: upstream valid/ready stream plus RAM write port of the fill controller
interface ram_fill_ctrl_if #(
  parameter int DW = ram_ctrl_pkg::DW,
  parameter int AW = ram_ctrl_pkg::AW
);
  logic s_valid;
  logic s_ready;
  logic [DW-1:0] s_data;
  logic we;
  logic [AW-1:0] wr_add;
  logic [DW-1:0] wr_data;
  modport slave (input s_valid, s_data, output s_ready, we, wr_add, wr_data);
  modport master (output s_valid, s_data, input s_ready, we, wr_add, wr_data);
endinterface

// File: rtl/ram_fill_ctrl.sv
// ram_fill_ctrl: fills an 8x16 RAM from a stream, holds until released, and sweeps it to zero on request
module ram_fill_ctrl #(
  parameter int DW = ram_ctrl_pkg::DW,
  parameter int AW = ram_ctrl_pkg::AW
) (
  input  logic           clk,
  input  logic           clr_n,
  ram_fill_ctrl_if.slave s,
  input  logic           zero_req,
  input  logic           rd_done,
  output logic           full,
  output logic           busy,
  output logic [AW:0]    count
);
  import ram_ctrl_pkg::*;
  localparam logic [AW-1:0] LAST = AW'((2 ** AW) - 1);
  state_e state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, wr_add_q, wr_add_d;
  logic [AW:0] count_q, count_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic we_q, we_d, full_q, full_d, busy_q, busy_d, hs;
  assign s.s_ready = (state_q == FILL) && !zero_req;
  assign hs = s.s_valid && s.s_ready;
  assign s.we = we_q;
  assign s.wr_add = wr_add_q;
  assign s.wr_data = wr_data_q;
  assign full = full_q;
  assign busy = busy_q;
  assign count = count_q;
  // the sweep issues address 0 on entry, so ptr returning to 0 marks its end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    count_d = count_q;
    full_d = full_q;
    busy_d = busy_q;
    we_d = 1'b0;
    wr_add_d = wr_add_q;
    wr_data_d = wr_data_q;
    if (state_q != ZERO && zero_req) begin
      state_d = ZERO;
      ptr_d = AW'(1);
      count_d = '0;
      full_d = 1'b0;
      busy_d = 1'b1;
      we_d = 1'b1;
      wr_add_d = '0;
      wr_data_d = '0;
    end else if (state_q == ZERO) begin
      if (ptr_q == '0) begin
        state_d = FILL;
        busy_d = 1'b0;
      end else begin
        we_d = 1'b1;
        wr_add_d = ptr_q;
        wr_data_d = '0;
        ptr_d = ptr_q + 1'b1;
      end
    end else if (hs) begin
      we_d = 1'b1;
      wr_add_d = ptr_q;
      wr_data_d = s.s_data;
      ptr_d = ptr_q + 1'b1;
      count_d = count_q + 1'b1;
      if (ptr_q == LAST) begin
        state_d = FULL;
        full_d = 1'b1;
      end
    end else if (state_q == FULL && rd_done) begin
      state_d = FILL;
      count_d = '0;
      full_d = 1'b0;
      ptr_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= FILL;
      ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      busy_q <= 1'b0;
      we_q <= 1'b0;
      wr_add_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      count_q <= count_d;
      full_q <= full_d;
      busy_q <= busy_d;
      we_q <= we_d;
      wr_add_q <= wr_add_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_ram_fill_ctrl.sv
// tb_ram_fill_ctrl: table vectors plus write scoreboard against a small behavioural model
module tb_ram_fill_ctrl;
  import ram_ctrl_pkg::*;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic zero_req = 1'b0;
  logic rd_done = 1'b0;
  logic full, busy;
  logic [AW:0] count;
  always #5 clk = ~clk;
  ram_fill_ctrl_if bus ();
  ram_fill_ctrl dut (
    .clk(clk),
    .clr_n(clr_n),
    .s(bus.slave),
    .zero_req(zero_req),
    .rd_done(rd_done),
    .full(full),
    .busy(busy),
    .count(count)
  );
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  typedef struct {
    bit rn, v;
    logic [DW-1:0] d;
    bit z, r;
    bit e_we, e_full, e_busy;
    int e_cnt;
    bit e_rdy;
  } vec_t;
  wr_t q[$];
  wr_t mon_e;
  vec_t tv[17];
  int tests = 0;
  int fails = 0;
  int m_st = 0, m_ptr = 0, m_cnt = 0, m_sweep = 0;
  bit m_we = 0, m_full = 0, m_busy = 0;
  int busy_n;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected at %0t", bus.wr_add, bus.wr_data, $time);
      end else begin
        mon_e = q.pop_front();
        if (bus.wr_add !== mon_e.a || bus.wr_data !== mon_e.d) begin
          fails++;
          $display("FAIL ram_write: got addr %0h data %0h expected addr %0h data %0h at %0t", bus.wr_add, bus.wr_data, mon_e.a, mon_e.d, $time);
        end
      end
    end
  end
  task automatic cyc(bit rn, bit v, logic [DW-1:0] d, bit z, bit r);
    clr_n = rn;
    bus.s_valid = v;
    bus.s_data = d;
    zero_req = z;
    rd_done = r;
    @(posedge clk);
    m_we = 0;
    if (!rn) begin
      m_st = 0; m_ptr = 0; m_cnt = 0; m_full = 0; m_busy = 0;
      q.delete();
    end else if (m_st != 2 && z) begin
      m_st = 2; m_sweep = 8; m_cnt = 0; m_full = 0; m_busy = 1; m_we = 1; m_ptr = 0;
      for (int i = 0; i < DEPTH; i++) q.push_back(wr_t'{a: AW'(i), d: '0});
    end else if (m_st == 2) begin
      m_sweep--;
      if (m_sweep == 0) begin
        m_st = 0; m_busy = 0;
      end else m_we = 1;
    end else if (m_st == 0 && v) begin
      q.push_back(wr_t'{a: AW'(m_ptr), d: d});
      m_ptr++; m_cnt++; m_we = 1;
      if (m_cnt == DEPTH) begin
        m_st = 1; m_full = 1; m_ptr = 0;
      end
    end else if (m_st == 1 && r) begin
      m_st = 0; m_cnt = 0; m_full = 0;
    end
    @(negedge clk);
    chk("we", bus.we, m_we);
    chk("full", full, m_full);
    chk("busy", busy, m_busy);
    chk("count", count, m_cnt);
    chk("s_ready", bus.s_ready, m_st == 0 && !z);
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    tv[0] = '{0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 1; i <= 8; i++) tv[i] = '{1, 1, 16'(i), 0, 0, 1, i == 8, 0, i, i < 8};
    for (int i = 9; i <= 13; i++) tv[i] = '{1, 1, 16'hDEAD, 0, 0, 0, 1, 0, 8, 0};
    tv[14] = '{1, 0, 16'h0, 0, 1, 0, 0, 0, 0, 1};
    tv[15] = '{1, 1, 16'h0101, 0, 0, 1, 0, 0, 1, 1};
    tv[16] = '{1, 0, 16'h0, 0, 0, 0, 0, 0, 1, 1};
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      cyc(tv[i].rn, tv[i].v, tv[i].d, tv[i].z, tv[i].r);
      chk($sformatf("tbl%0d_we", i), bus.we, tv[i].e_we);
      chk($sformatf("tbl%0d_full", i), full, tv[i].e_full);
      chk($sformatf("tbl%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("tbl%0d_count", i), count, tv[i].e_cnt);
      chk($sformatf("tbl%0d_ready", i), bus.s_ready, tv[i].e_rdy);
    end
    cyc(1, 1, 16'h0102, 0, 0);
    cyc(1, 1, 16'h0103, 0, 0);
    busy_n = 0;
    cyc(1, 1, 16'hBEEF, 1, 0);
    busy_n += int'(busy);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 16'hBEEF, i == 3, 0);
      busy_n += int'(busy);
    end
    chk("busy_len", busy_n, 8);
    cyc(1, 1, 16'hBEEF, 0, 0);
    chk("pending_accepted_addr", bus.wr_add, 0);
    for (int i = 0; i < 7; i++) cyc(1, 1, 16'h0200 + 16'(i), 0, 0);
    chk("full_before_race", full, 1);
    cyc(1, 0, 16'h0, 1, 1);
    chk("race_sweep", busy, 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 16'h0, 0, 0);
    chk("race_ready", bus.s_ready, 1);
    cyc(1, 0, 16'h0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 16'h0, 0, 0);
    chk("abort_addr", bus.wr_add, 4);
    cyc(0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 200 && m_st != 1; j++) cyc(1, 1'($urandom % 2), 16'($urandom), 0, 0);
      chk($sformatf("round%0d_full", k), full, 1);
      cyc(1, 1, 16'hDEAD, 0, 0);
      cyc(1, 0, 16'h0, 0, 1);
      cyc(1, 0, 16'h0, 0, 0);
    end
    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
